// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT FSM
// with a memory wait timeout, a sticky error flag and a retired-instruction counter.
module multicycle_sequencer #(
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [2:0]             instr_class,
  input  logic                   mem_ready,
  input  logic                   branch_taken,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic                   operand_write,
  output logic                   alu_out_write,
  output logic                   mdr_write,
  output logic                   reg_write,
  output logic                   wb_src,
  output logic [2:0]             state,
  output logic                   halted,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5
  } state_e;

  localparam logic [2:0] ClsAlu    = 3'd0;
  localparam logic [2:0] ClsLoad   = 3'd1;
  localparam logic [2:0] ClsStore  = 3'd2;
  localparam logic [2:0] ClsBranch = 3'd3;
  localparam logic [2:0] ClsJump   = 3'd4;
  localparam logic [2:0] ClsHalt   = 3'd5;

  localparam int unsigned   WaitW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [2:0]             class_q, class_d;
  logic                   error_q, error_d;
  logic [WaitW-1:0]       wait_q, wait_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  logic                   retire;
  logic                   wait_hit;

  // This cycle would be the MEM_TIMEOUT-th consecutive wait without mem_ready.
  assign wait_hit = !mem_ready && (wait_q == WaitLast);

  always_comb begin
    state_d       = state_q;
    class_d       = class_q;
    error_d       = error_q;
    retire        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'd0;
    operand_write = 1'b0;
    alu_out_write = 1'b0;
    mdr_write     = 1'b0;
    reg_write     = 1'b0;
    wb_src        = 1'b0;
    halted        = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (wait_hit) begin
          error_d = 1'b1;
          state_d = StHalt;
        end
      end
      StDecode: begin
        class_d       = instr_class;
        operand_write = 1'b1;
        case (instr_class)
          ClsAlu, ClsLoad, ClsStore, ClsBranch: state_d = StExecute;
          ClsJump: begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
            retire   = 1'b1;
            state_d  = StFetch;
          end
          ClsHalt: state_d = StHalt;
          default: begin
            error_d = 1'b1;
            state_d = StHalt;
          end
        endcase
      end
      StExecute: begin
        alu_out_write = 1'b1;
        case (class_q)
          ClsAlu:           state_d = StWriteback;
          ClsLoad, ClsStore: state_d = StMemory;
          ClsBranch: begin
            pc_write = branch_taken;
            pc_src   = 2'd1;
            retire   = 1'b1;
            state_d  = StFetch;
          end
          default:          state_d = StFetch;
        endcase
      end
      StMemory: begin
        if (class_q == ClsStore) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end else begin
          mem_read = 1'b1;
          if (mem_ready) begin
            mdr_write = 1'b1;
            state_d   = StWriteback;
          end
        end
        if (wait_hit) begin
          error_d = 1'b1;
          state_d = StHalt;
        end
      end
      StWriteback: begin
        reg_write = 1'b1;
        wb_src    = (class_q == ClsLoad);
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StHalt:  halted = 1'b1;
      default: state_d = StFetch;
    endcase

    // Strobes are held low for the whole reset cycle, even mid-access.
    if (!reset_n) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 2'd0;
      operand_write = 1'b0;
      alu_out_write = 1'b0;
      mdr_write     = 1'b0;
      reg_write     = 1'b0;
      wb_src        = 1'b0;
      halted        = 1'b0;
    end
  end

  always_comb begin
    wait_d    = wait_q;
    retired_d = retire ? retired_q + COUNT_WIDTH'(1) : retired_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == StFetch || state_q == StMemory) && !mem_ready) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      class_q   <= 3'd0;
      error_q   <= 1'b0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      error_q   <= error_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign error   = error_q;
  assign retired = retired_q;

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter COUNT_WIDTH, default 16: width of the retired-instruction counter.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum number of cycles allowed waiting for mem_ready.
REQ-003 Port clock, input, 1: single clock; all state updates occur on the rising edge.
REQ-004 Port reset_n, input, 1: reset is synchronous and active-low.
REQ-005 Port instr_class, input, 3: instruction class from the IR, sampled in DECODE. Encoding: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 HALT, 6-7 illegal.
REQ-006 Port mem_ready, input, 1: memory completes the current read or write in this cycle.
REQ-007 Port branch_taken, input, 1: ALU branch condition, valid in EXECUTE.
REQ-008 Port mem_read, output, 1: memory read strobe.
REQ-009 Port mem_write, output, 1: memory write strobe.
REQ-010 Port ir_write, output, 1: IR register enable.
REQ-011 Port pc_write, output, 1: PC register enable.
REQ-012 Port pc_src, output, 2: PC next-value source. 0 = PC+4, 1 = branch target, 2 = jump target.
REQ-013 Port operand_write, output, 1: A/B operand register enable.
REQ-014 Port alu_out_write, output, 1: ALUOut register enable.
REQ-015 Port mdr_write, output, 1: MDR register enable.
REQ-016 Port reg_write, output, 1: register-file write enable.
REQ-017 Port wb_src, output, 1: write-back source. 0 = ALUOut, 1 = MDR.
REQ-018 Port state, output, 3: current state encoding.
REQ-019 Port halted, output, 1: high while in HALT.
REQ-020 Port error, output, 1: sticky flag for an illegal class or a memory timeout.
REQ-021 Port retired, output, COUNT_WIDTH: count of completed instructions.

Function
REQ-022 The state register SHALL use this encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
REQ-023 Control outputs SHALL be combinational from state, the latched class, mem_ready and branch_taken; any output not listed for a state SHALL be 0.
REQ-024 FETCH SHALL behave as follows:
- mem_read=1 continuously.
- With mem_ready=0: remain in FETCH.
- With mem_ready=1: ir_write=1, pc_write=1, pc_src=0; next state DECODE.
REQ-025 DECODE SHALL behave as follows:
- Latch instr_class; operand_write=1.
- Classes 0-3: next state EXECUTE.
- Class 4: pc_write=1, pc_src=2, retire; next state FETCH.
- Class 5: next state HALT.
- Classes 6-7: set error; next state HALT.
REQ-026 EXECUTE SHALL behave as follows:
- alu_out_write=1.
- ALU: next state WRITEBACK.
- LOAD or STORE: next state MEMORY.
- BRANCH: pc_write=branch_taken, pc_src=1, retire; next state FETCH.
REQ-027 MEMORY with a LOAD class SHALL behave as follows:
- mem_read=1 continuously.
- With mem_ready=1: mdr_write=1; next state WRITEBACK.
REQ-028 MEMORY with a STORE class SHALL behave as follows:
- mem_write=1 continuously.
- With mem_ready=1: retire; next state FETCH.
REQ-029 WRITEBACK SHALL assert reg_write=1, set wb_src=1 for LOAD and 0 for ALU, retire, and move to FETCH.
REQ-030 HALT SHALL assert halted=1 with all enables 0, and SHALL exit only through reset.
REQ-031 A wait counter SHALL behave as follows:
- Clears on every state change.
- Increments each cycle spent in FETCH or MEMORY with mem_ready=0.
- When it reaches MEM_TIMEOUT with mem_ready still 0: set error; next state HALT.
REQ-032 mem_ready=1 in the same cycle as the timeout SHALL take priority, and the access SHALL complete normally.
REQ-033 retired SHALL increment by exactly 1 per retire event and wrap modulo 2^COUNT_WIDTH with no flag.
REQ-034 mem_ready SHALL be ignored in DECODE, EXECUTE, WRITEBACK and HALT.
REQ-035 branch_taken SHALL be ignored outside EXECUTE with a BRANCH class.
REQ-036 Cycle counts for an instruction with zero memory wait states SHALL be:

| Class | Cycles |
|---|---|
| ALU | 4 |
| LOAD | 5 |
| STORE | 4 |
| BRANCH | 3 |
| JUMP | 2 |

Reset
REQ-037 On a rising edge with reset_n=0, the block SHALL set state=FETCH, clear retired, error, the wait counter and the latched class, and take priority over every transition, including mid-access.
REQ-038 While reset_n=0, all control outputs SHALL be forced to 0.
REQ-039 The first mem_read SHALL assert in the first cycle after reset_n returns to 1.

Verification
REQ-040 ALU instruction, class 0, mem_ready tied 1 -> states 0,1,2,4,0; reg_write high only in cycle 4 with wb_src=0; retired 0->1.
REQ-041 LOAD with mem_ready low for 3 cycles in MEMORY -> MEMORY held for 4 cycles; mdr_write pulses once; WRITEBACK has wb_src=1; total 8 cycles.
REQ-042 BRANCH with branch_taken=1, then BRANCH with branch_taken=0 -> first has pc_write=1, pc_src=1 in EXECUTE; second has pc_write=0; retired increases by 2.
REQ-043 mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> error=1 and state=5 after 15 wait cycles; halted stays 1 until reset_n=0.
REQ-044 Class 7 in DECODE -> error=1, HALT. Then reset_n=0 for one edge -> state=0, error=0, retired=0.
REQ-045 With COUNT_WIDTH=4, retire 17 JUMP instructions -> retired wraps from 15 to 0 and ends at 1.
REQ-046 reset_n=0 asserted during a STORE wait in MEMORY -> mem_write drops to 0 immediately; next state is FETCH; retired is cleared to 0.
